// File: rtl/dp_pkg.sv
// Shared types and constants for the count/sum dedicated processor.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_SUM   = 1'b1;

endpackage

// File: rtl/count_sum_datapath.sv
// Datapath for count_sum_processor: A/SUM counters, latched run parameters
// and the output buffer, driven by a ClrAB/Load/Step/Latch control set.
module count_sum_datapath
  import dp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_latch,
  input  logic             i_clr_ab,
  input  logic             i_step,
  input  logic             i_load,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_a_lt_limit,
  output logic [WIDTH-1:0] o_out
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_limit_q;
  logic [WIDTH-1:0] r_out;
  logic             r_mode_q;
  logic [WIDTH-1:0] w_sum_next;

  // SUM wraps modulo 2^WIDTH; A cannot wrap because it stops at limit_q.
  assign w_sum_next   = r_sum + r_a;
  assign o_a_lt_limit = (r_a < r_limit_q);
  assign o_out        = r_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_sum     <= '0;
      r_limit_q <= '0;
      r_mode_q  <= MODE_COUNT;
      r_out     <= '0;
    end else begin
      if (i_latch) begin
        r_mode_q  <= i_mode;
        r_limit_q <= i_limit;
      end
      if (i_clr_ab) begin
        r_a   <= '0;
        r_sum <= '0;
      end else if (i_step) begin
        r_a   <= r_a + 1'b1;
        r_sum <= w_sum_next;
      end
      if (i_load) begin
        r_out <= (r_mode_q == MODE_SUM) ? w_sum_next : r_a;
      end
    end
  end

endmodule

// File: rtl/count_sum_processor.sv
// Count/sum dedicated processor: FSM, step prescaler and datapath instance.
// Define DP_PRESCALER_EN to step once per PRESCALE clocks; otherwise every clock.
module count_sum_processor
  import dp_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 30_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_t r_state;
  state_t w_state_next;
  logic   w_tick;
  logic   w_a_lt_limit;
  logic   w_latch;
  logic   w_clr_ab;
  logic   w_step;

`ifdef DP_PRESCALER_EN
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] r_ps_cnt;

  assign w_tick = (r_ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ps_cnt <= '0;
    end else if (w_tick) begin
      r_ps_cnt <= '0;
    end else begin
      r_ps_cnt <= r_ps_cnt + 1'b1;
    end
  end
`else
  // PRESCALE must be at least 1, so this is a constant-high tick.
  assign w_tick = (PRESCALE >= 1);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // IDLE and DONE advance every clock; LOAD and RUN advance only on a tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start) w_state_next = LOAD;
      LOAD: if (w_tick) w_state_next = RUN;
      RUN:  if (w_tick && !w_a_lt_limit) w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_latch  = (r_state == IDLE) && start;
  assign w_clr_ab = (r_state == LOAD) && w_tick;
  assign w_step   = (r_state == RUN) && w_tick && w_a_lt_limit;

  assign busy = (r_state == LOAD) || (r_state == RUN);
  assign done = (r_state == DONE);

  count_sum_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk          (clk),
    .rst_n        (reset),
    .i_latch      (w_latch),
    .i_clr_ab     (w_clr_ab),
    .i_step       (w_step),
    .i_load       (w_step),
    .i_mode       (mode),
    .i_limit      (limit),
    .o_a_lt_limit (w_a_lt_limit),
    .o_out        (out)
  );

endmodule

// File: tb/tb_count_sum_processor.sv
// Directed self-checking bench for count_sum_processor (WIDTH=8, tick every clk).
module tb_count_sum_processor;

  logic       clk;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] limit;
  logic       busy;
  logic       done;
  logic [7:0] out;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         busy_cnt;
  int         done_cnt;
  bit         overlap;

  count_sum_processor #(
    .WIDTH    (8),
    .PRESCALE (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .limit (limit),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one clock, then sample every negedge until done (bounded).
  // Out is recorded from the third busy cycle onwards, where each step's value is visible.
  task automatic do_run(input logic m, input logic [7:0] lim, input int repulse);
    bit seen_done;
    obs_q.delete();
    busy_cnt  = 0;
    done_cnt  = 0;
    overlap   = 0;
    seen_done = 0;
    @(negedge clk);
    mode  = m;
    limit = lim;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 600; k++) begin
      if (busy) begin
        if (busy_cnt >= 2) obs_q.push_back(out);
        if (busy_cnt == repulse) begin
          start = 1'b1;
          limit = 8'd3;
        end else begin
          start = 1'b0;
        end
        busy_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (busy) overlap = 1;
        seen_done = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    check("done_no_busy", {31'd0, overlap}, 32'd0);
    @(negedge clk);
    check("done_one_clk", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    limit    = 8'd0;
    #1;
    check("rst_out", {24'd0, out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    repeat (4) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_out", {24'd0, out}, 32'd0);

    // Count mode, limit 10.
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    do_run(1'b0, 8'd10, -1);
    check("cnt_busy_len", busy_cnt, 32'd12);
    check("cnt_done_cnt", done_cnt, 32'd1);
    compare_seq("cnt");
    repeat (3) @(negedge clk);
    check("cnt_hold", {24'd0, out}, 32'd9);

    // Sum mode, limit 10.
    exp_q = '{8'd0, 8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd21, 8'd28, 8'd36, 8'd45};
    do_run(1'b1, 8'd10, -1);
    check("sum_busy_len", busy_cnt, 32'd12);
    compare_seq("sum");
    check("sum_final", {24'd0, out}, 32'd45);

    // limit 0: no RUN update, out keeps 45.
    exp_q.delete();
    do_run(1'b0, 8'd0, -1);
    check("lim0_busy_len", busy_cnt, 32'd2);
    check("lim0_done_cnt", done_cnt, 32'd1);
    compare_seq("lim0");
    check("lim0_out", {24'd0, out}, 32'd45);

    // Sum mode, limit 255: 32385 mod 256 = 129.
    exp_q.delete();
    do_run(1'b1, 8'd255, -1);
    check("big_busy_len", busy_cnt, 32'd257);
    check("big_steps", obs_q.size(), 32'd255);
    check("big_final", {24'd0, out}, 32'd129);

    // Start re-pulsed mid-RUN with limit=3 must not affect the run.
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    do_run(1'b0, 8'd10, 5);
    check("rep_busy_len", busy_cnt, 32'd12);
    compare_seq("rep");

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    mode  = 1'b1;
    limit = 8'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out", {24'd0, out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_out", {24'd0, out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_sum_processor.md
# count_sum_processor

Parametrised dedicated processor: a control-unit/datapath pair that counts a register A from 0 up to a runtime limit and either streams A or the running sum 0+1+…+A to an output buffer. Successor to the fixed count-to-10 processor. Adds generic width, a runtime limit and mode, a start/busy/done handshake, and a clock-enable prescaler in place of a derived clock. Sits at the top level driving LEDs or seven-segment logic, one step per prescaler tick.

## Interface
- WIDTH, 8: width of A, SUM, limit and out.
- PRESCALE, 30_000_000: clk cycles per step tick; ≥1. Used only when DP_PRESCALER_EN is defined.
- clk  input  1  system clock; the only clock, all flops on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request a run; sampled every clk in IDLE.
- mode  input  1  0 = count mode (out ← A), 1 = sum mode (out ← running sum); latched on start.
- limit  input  WIDTH  run while A < limit; latched on start.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-clk pulse in DONE.
- out  output  WIDTH  output buffer register.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Moore outputs decoded from the state register.
- IDLE: start=1 → LOAD on the next clk, not tick-gated; latch mode_q and limit_q.
- LOAD: on a tick, A←0 and SUM←0, → RUN.
- RUN, on each tick:
  - if A < limit_q: A←A+1, SUM←SUM+A, out←(mode_q ? SUM+A : A), stay in RUN.
  - else → DONE; A, SUM and out hold.
- DONE: lasts exactly one clk, not tick-gated, then → IDLE.
- Without a tick, LOAD and RUN hold all state.
- Arithmetic:
  - A < limit_q guarantees that A never wraps.
  - SUM and out wrap modulo 2^WIDTH; no saturation.
- start outside IDLE is ignored. Inputs are not re-latched mid-run.
- limit=0: LOAD → RUN → DONE with out unchanged.
- out holds its last value across IDLE and later runs until the next RUN update.
- Reset mid-run: asynchronous return to IDLE. All registers cleared.

## Timing
- Reset values: state=IDLE, A=0, SUM=0, mode_q=0, limit_q=0, out=0, busy=0, done=0, prescaler count=0.
- start high in cycle t: busy=1 from cycle t+1.
- A run of limit N spans N+2 ticks from LOAD entry, plus one DONE clk. busy falls the same clk done rises.
- With tick every clk, out first updates 2 clks after busy rises, then once per clk.

## Configuration
- DP_PRESCALER_EN defined:
  - free-running counter 0..PRESCALE-1, starting from reset;
  - tick is a one-clk pulse when count==PRESCALE-1, then count←0;
  - PRESCALE=1 gives a tick every clk.
- DP_PRESCALER_EN undefined: no counter; tick is constant 1, so one step per clk (simulation/fast builds).
- The FSM and datapath are identical in both builds.

## Structure
- Shared package dp_pkg:
  - state enum (IDLE, LOAD, RUN, DONE);
  - MODE_COUNT=0 and MODE_SUM=1 constants.
- Sub-module count_sum_datapath:
  - holds A, SUM, mode_q, limit_q and out, with a ClrAB/Load/Step/Latch control set;
  - drives the A<limit_q status back to the top.
- FSM and prescaler stay in count_sum_processor.

## Test plan
All scenarios: WIDTH=8, tick every clk.
- Reset low mid-stream → out=0, busy=0, done=0 immediately. After release, start is required before anything moves.
- mode=0, limit=10, start pulse → out steps 0,1,…,9. busy high for 12 clks. done pulses once; out holds 9.
- mode=1, limit=10 → out 0,1,3,6,10,15,21,28,36,45; final 45.
- mode=1, limit=255 → final out = 32385 mod 256 = 129; A never wraps.
- limit=0 after a previous run ended at 45 → busy 2 clks, done pulse, out stays 45.
- start re-pulsed during RUN with limit=3 → ignored; run completes with the original limit. With DP_PRESCALER_EN and PRESCALE=4, steps are spaced 4 clks apart.
